// File: rtl/if_id_skid_reg.sv
// Fetch-to-decode pipeline register with a one-entry skid buffer and synchronous flush.
// in_ready is registered, so fetch never sees a combinational path from decode.
module if_id_skid_reg #(
  parameter int unsigned           PC_W     = 32,
  parameter int unsigned           INST_W   = 32,
  parameter logic [INST_W-1:0]     NOP_INST = INST_W'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e              state_q;
  logic [PC_W-1:0]     main_pc_q;
  logic [INST_W-1:0]   main_inst_q;
  logic [PC_W-1:0]     skid_pc_q;
  logic [INST_W-1:0]   skid_inst_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [1:0]          occ_q;

  logic accept;
  logic consume;

  always_comb begin
    accept  = in_valid && in_ready_q;
    consume = out_valid_q && out_ready;
  end

  // Handshake flags and occupancy are registered alongside the state so they
  // always mirror it without any combinational decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_pc_q   <= '0;
      main_inst_q <= NOP_INST;
      skid_pc_q   <= '0;
      skid_inst_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else if (flush) begin
      state_q     <= EMPTY;
      main_inst_q <= NOP_INST;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q     <= ONE;
            main_pc_q   <= in_pc;
            main_inst_q <= in_inst;
            out_valid_q <= 1'b1;
            occ_q       <= 2'd1;
          end
        end
        ONE: begin
          case ({accept, consume})
            2'b11: begin
              main_pc_q   <= in_pc;
              main_inst_q <= in_inst;
            end
            2'b10: begin
              state_q     <= FULL;
              skid_pc_q   <= in_pc;
              skid_inst_q <= in_inst;
              in_ready_q  <= 1'b0;
              occ_q       <= 2'd2;
            end
            2'b01: begin
              state_q     <= EMPTY;
              main_inst_q <= NOP_INST;
              out_valid_q <= 1'b0;
              occ_q       <= 2'd0;
            end
            default: ;
          endcase
        end
        FULL: begin
          if (consume) begin
            state_q     <= ONE;
            main_pc_q   <= skid_pc_q;
            main_inst_q <= skid_inst_q;
            in_ready_q  <= 1'b1;
            occ_q       <= 2'd1;
          end
        end
        default: begin
          state_q     <= EMPTY;
          main_inst_q <= NOP_INST;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          occ_q       <= 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    in_ready  = in_ready_q;
    out_valid = out_valid_q;
    out_pc    = main_pc_q;
    out_inst  = main_inst_q;
    occupancy = occ_q;
  end

endmodule
